// File: rtl/clock_calendar_hex.sv
// Binary time-of-day (hh:mm:ss) and calendar (dd.mm.yyyy) keeper.
// Advances one second per tick; the date rolls when the time passes midnight.
module clock_calendar_hex #(
    parameter logic [11:0] RST_YEAR = 12'd2000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tick,
    input  logic        time_ow,
    input  logic [16:0] time_in,
    input  logic        date_ow,
    input  logic [20:0] date_in,
    output logic [16:0] time_out,
    output logic [20:0] date_out
);

    logic [16:0] time_q, time_inc;
    logic [20:0] date_q, date_inc;
    logic        day_adv;

    logic [4:0]  hour, day;
    logic [5:0]  min, sec;
    logic [3:0]  month;
    logic [11:0] year;

    function automatic logic is_leap(input logic [11:0] y);
        is_leap = (y[1:0] == 2'b00) &&
                  (((y % 12'd100) != 12'd0) || ((y % 12'd400) == 12'd0));
    endfunction

    // Unlisted month codes (0, 13-15) are treated as 31-day months.
    function automatic logic [4:0] days_in_month(input logic [3:0] m, input logic [11:0] y);
        case (m)
            4'd2:                    days_in_month = is_leap(y) ? 5'd29 : 5'd28;
            4'd4, 4'd6, 4'd9, 4'd11: days_in_month = 5'd30;
            default:                 days_in_month = 5'd31;
        endcase
    endfunction

    assign hour  = time_q[16:12];
    assign min   = time_q[11:6];
    assign sec   = time_q[5:0];
    assign day   = date_q[20:16];
    assign month = date_q[15:12];
    assign year  = date_q[11:0];

    assign day_adv = tick & ~time_ow & (hour >= 5'd23) & (min >= 6'd59) & (sec >= 6'd59);

    // The >= comparisons let out-of-range loaded fields recover at their next wrap.
    always_comb begin
        time_inc = time_q;
        if (sec >= 6'd59) begin
            time_inc[5:0] = 6'd0;
            if (min >= 6'd59) begin
                time_inc[11:6] = 6'd0;
                time_inc[16:12] = (hour >= 5'd23) ? 5'd0 : hour + 5'd1;
            end else begin
                time_inc[11:6] = min + 6'd1;
            end
        end else begin
            time_inc[5:0] = sec + 6'd1;
        end
    end

    always_comb begin
        date_inc = date_q;
        if (day >= days_in_month(month, year)) begin
            date_inc[20:16] = 5'd1;
            if ((month >= 4'd12) || (month == 4'd0)) begin
                date_inc[15:12] = 4'd1;
                date_inc[11:0]  = year + 12'd1;
            end else begin
                date_inc[15:12] = month + 4'd1;
            end
        end else begin
            date_inc[20:16] = day + 5'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            time_q <= 17'd0;
            date_q <= {5'd1, 4'd1, RST_YEAR};
        end else begin
            if (time_ow)
                time_q <= time_in;
            else if (tick)
                time_q <= time_inc;

            if (date_ow)
                date_q <= date_in;
            else if (day_adv)
                date_q <= date_inc;
        end
    end

    assign time_out = time_q;
    assign date_out = date_q;

endmodule

// File: tb/tb_clock_calendar_hex.sv
// Self-checking bench for clock_calendar_hex: expected time/date values are queued
// as stimulus is applied and compared once the registered outputs settle.
module tb_clock_calendar_hex;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        tick = 1'b0;
    logic        time_ow = 1'b0;
    logic [16:0] time_in = '0;
    logic        date_ow = 1'b0;
    logic [20:0] date_in = '0;
    logic [16:0] time_out;
    logic [20:0] date_out;

    typedef struct {
        string       name;
        logic [16:0] t;
        logic [20:0] d;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   n_cmp = 0;
    int   n_fail = 0;

    clock_calendar_hex #(.RST_YEAR(12'd2000)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .tick     (tick),
        .time_ow  (time_ow),
        .time_in  (time_in),
        .date_ow  (date_ow),
        .date_in  (date_in),
        .time_out (time_out),
        .date_out (date_out)
    );

    always #5 clk = ~clk;

    function automatic logic [16:0] mk_t(input int h, input int m, input int s);
        logic [4:0] hh;
        logic [5:0] mm, ss;
        hh = h[4:0];
        mm = m[5:0];
        ss = s[5:0];
        mk_t = {hh, mm, ss};
    endfunction

    function automatic logic [20:0] mk_d(input int d, input int m, input int y);
        logic [4:0]  dd;
        logic [3:0]  mo;
        logic [11:0] yy;
        dd = d[4:0];
        mo = m[3:0];
        yy = y[11:0];
        mk_d = {dd, mo, yy};
    endfunction

    function automatic exp_t mk_e(input string n, input logic [16:0] t, input logic [20:0] d);
        exp_t x;
        x.name = n;
        x.t = t;
        x.d = d;
        return x;
    endfunction

    // One clock with the given inputs; returns #1 after the rising edge with strobes cleared.
    task automatic cyc(input logic tk, input logic tow, input logic [16:0] ti,
                       input logic dow, input logic [20:0] di);
        tick = tk;
        time_ow = tow;
        time_in = ti;
        date_ow = dow;
        date_in = di;
        @(posedge clk);
        #1;
        tick = 1'b0;
        time_ow = 1'b0;
        date_ow = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, '0, 1'b0, '0);
    endtask

    task automatic load(input logic [16:0] t, input logic [20:0] d);
        cyc(1'b0, 1'b1, t, 1'b1, d);
    endtask

    task automatic test_reset;
        exp_q.push_back(mk_e("reset_low", 17'h0, mk_d(1, 1, 2000)));
        repeat (2) @(posedge clk);
        #1;
        e = exp_q.pop_front();
        n_cmp++;
        if (time_out !== e.t || date_out !== e.d) begin
            n_fail++;
            $display("FAIL %s: time=%h date=%h, expected time=%h date=%h", e.name, time_out, date_out, e.t, e.d);
        end
        rst_n = 1'b1;
        load(mk_t(23, 48, 0), mk_d(15, 1, 2020));
        #3;
        rst_n = 1'b0;
        exp_q.push_back(mk_e("async_reset_midcycle", 17'h0, {5'd1, 4'd1, 12'd2000}));
        exp_q.push_back(mk_e("reset_holds_vs_tick", 17'h0, {5'd1, 4'd1, 12'd2000}));
        exp_q.push_back(mk_e("idle_hold_1", 17'h0, {5'd1, 4'd1, 12'd2000}));
        exp_q.push_back(mk_e("idle_hold_2", 17'h0, {5'd1, 4'd1, 12'd2000}));
        exp_q.push_back(mk_e("idle_hold_3", 17'h0, {5'd1, 4'd1, 12'd2000}));
        for (int i = 0; i < 5; i++) begin
            if (i == 0) #1;
            else if (i == 1) begin
                @(negedge clk);
                cyc(1'b1, 1'b0, '0, 1'b0, '0);
                rst_n = 1'b1;
            end else cyc(1'b0, 1'b0, '0, 1'b0, '0);
            e = exp_q.pop_front();
            n_cmp++;
            if (time_out !== e.t || date_out !== e.d) begin
                n_fail++;
                $display("FAIL %s: time=%h date=%h, expected time=%h date=%h", e.name, time_out, date_out, e.t, e.d);
            end
        end
    endtask

    task automatic test_count;
        exp_q.push_back(mk_e("load_both", 17'b10111_110000_000000, mk_d(15, 1, 2020)));
        exp_q.push_back(mk_e("after_719", mk_t(23, 59, 59), mk_d(15, 1, 2020)));
        exp_q.push_back(mk_e("after_720", mk_t(0, 0, 0), mk_d(16, 1, 2020)));
        for (int i = 0; i < 3; i++) begin
            if (i == 0) load(mk_t(23, 48, 0), mk_d(15, 1, 2020));
            else if (i == 1) ticks(719);
            else ticks(1);
            e = exp_q.pop_front();
            n_cmp++;
            if (time_out !== e.t || date_out !== e.d) begin
                n_fail++;
                $display("FAIL %s: time=%h date=%h, expected time=%h date=%h", e.name, time_out, date_out, e.t, e.d);
            end
        end
    endtask

    task automatic test_midnight_wraps;
        logic [20:0] start_d[9];
        string       names[9];
        start_d[0] = mk_d(30, 4, 2021);  names[0] = "apr30_2021";
        start_d[1] = mk_d(31, 12, 2020); names[1] = "dec31_2020";
        start_d[2] = mk_d(31, 12, 4095); names[2] = "dec31_4095";
        start_d[3] = mk_d(28, 2, 2020);  names[3] = "feb28_2020_leap";
        start_d[4] = mk_d(29, 2, 2020);  names[4] = "feb29_2020";
        start_d[5] = mk_d(28, 2, 2100);  names[5] = "feb28_2100";
        start_d[6] = mk_d(28, 2, 2000);  names[6] = "feb28_2000";
        start_d[7] = mk_d(28, 2, 2021);  names[7] = "feb28_2021";
        start_d[8] = mk_d(31, 4, 2021);  names[8] = "apr31_out_of_range";
        exp_q.push_back(mk_e(names[0], 17'h0, mk_d(1, 5, 2021)));
        exp_q.push_back(mk_e(names[1], 17'h0, mk_d(1, 1, 2021)));
        exp_q.push_back(mk_e(names[2], 17'h0, mk_d(1, 1, 0)));
        exp_q.push_back(mk_e(names[3], 17'h0, mk_d(29, 2, 2020)));
        exp_q.push_back(mk_e(names[4], 17'h0, mk_d(1, 3, 2020)));
        exp_q.push_back(mk_e(names[5], 17'h0, mk_d(1, 3, 2100)));
        exp_q.push_back(mk_e(names[6], 17'h0, mk_d(29, 2, 2000)));
        exp_q.push_back(mk_e(names[7], 17'h0, mk_d(1, 3, 2021)));
        exp_q.push_back(mk_e(names[8], 17'h0, mk_d(1, 5, 2021)));
        for (int i = 0; i < 9; i++) begin
            // Case 4 continues from the date left by case 3; only the time is reloaded.
            if (i == 4) cyc(1'b0, 1'b1, mk_t(23, 59, 59), 1'b0, '0);
            else load(mk_t(23, 59, 59), start_d[i]);
            ticks(1);
            e = exp_q.pop_front();
            n_cmp++;
            if (time_out !== e.t || date_out !== e.d) begin
                n_fail++;
                $display("FAIL %s: time=%h date=%h, expected time=%h date=%h", e.name, time_out, date_out, e.t, e.d);
            end
        end
    endtask

    task automatic test_priority;
        exp_q.push_back(mk_e("time_ow_beats_midnight", mk_t(12, 0, 0), mk_d(10, 10, 2022)));
        exp_q.push_back(mk_e("date_ow_at_midnight", mk_t(0, 0, 0), mk_d(5, 6, 2022)));
        exp_q.push_back(mk_e("time_ow_beats_tick", mk_t(7, 7, 7), mk_d(5, 6, 2022)));
        for (int i = 0; i < 3; i++) begin
            load(mk_t(23, 59, 59), mk_d(10, 10, 2022));
            if (i == 0) cyc(1'b1, 1'b1, mk_t(12, 0, 0), 1'b0, '0);
            else if (i == 1) cyc(1'b1, 1'b0, '0, 1'b1, mk_d(5, 6, 2022));
            else begin
                load(mk_t(3, 3, 3), mk_d(5, 6, 2022));
                cyc(1'b1, 1'b1, mk_t(7, 7, 7), 1'b0, '0);
            end
            e = exp_q.pop_front();
            n_cmp++;
            if (time_out !== e.t || date_out !== e.d) begin
                n_fail++;
                $display("FAIL %s: time=%h date=%h, expected time=%h date=%h", e.name, time_out, date_out, e.t, e.d);
            end
        end
    endtask

    task automatic test_carries;
        logic [16:0] start_t[4];
        start_t[0] = mk_t(10, 20, 63);
        start_t[1] = mk_t(10, 20, 59);
        start_t[2] = mk_t(9, 59, 59);
        start_t[3] = mk_t(22, 59, 59);
        exp_q.push_back(mk_e("sec63_recovers", mk_t(10, 21, 0), mk_d(3, 3, 2023)));
        exp_q.push_back(mk_e("min_carry", mk_t(10, 21, 0), mk_d(3, 3, 2023)));
        exp_q.push_back(mk_e("hour_carry", mk_t(10, 0, 0), mk_d(3, 3, 2023)));
        exp_q.push_back(mk_e("hour22_no_day_adv", mk_t(23, 0, 0), mk_d(3, 3, 2023)));
        for (int i = 0; i < 4; i++) begin
            load(start_t[i], mk_d(3, 3, 2023));
            ticks(1);
            e = exp_q.pop_front();
            n_cmp++;
            if (time_out !== e.t || date_out !== e.d) begin
                n_fail++;
                $display("FAIL %s: time=%h date=%h, expected time=%h date=%h", e.name, time_out, date_out, e.t, e.d);
            end
        end
    endtask

    task automatic test_back_to_back;
        load(mk_t(0, 0, 57), mk_d(1, 1, 2000));
        for (int i = 0; i < 5; i++)
            exp_q.push_back(mk_e($sformatf("held_tick_%0d", i),
                                 mk_t(0, (58 + i) / 60, (58 + i) % 60), mk_d(1, 1, 2000)));
        tick = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            n_cmp++;
            if (time_out !== e.t || date_out !== e.d) begin
                n_fail++;
                $display("FAIL %s: time=%h date=%h, expected time=%h date=%h", e.name, time_out, date_out, e.t, e.d);
            end
        end
        tick = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at %0t, expected to finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_count();
        test_midnight_wraps();
        test_priority();
        test_carries();
        test_back_to_back();
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
